alien_fleet: RTL

//  Target end of the ship/laser interface. Owns the invader grid (alive bitmap), marches it, and resolves hits from the ship laser box.

---
 rtl/invaders_pkg.sv | 17 +
 rtl/alien_bomb.sv | 74 +++++++
 rtl/alien_fleet.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// Shared screen geometry and fleet state encoding for the invaders game blocks.
package invaders_pkg;
    localparam int X_BOUND = 639;
    localparam int Y_BOUND = 479;
    localparam int SHIP_T  = 459;
    localparam int SHIP_B  = 479;
    localparam int TICK_Y  = 481;

    typedef enum logic [2:0] {
        MARCH_R = 3'd0,
        MARCH_L = 3'd1,
        DROP_L  = 3'd2,
        DROP_R  = 3'd3,
        LANDED  = 3'd4,
        CLEARED = 3'd5
    } fleet_state_e;
endpackage

// File: rtl/alien_bomb.sv
// Single falling bomb: launch, per-frame fall, bottom-of-screen retire and ship overlap.
module alien_bomb
    import invaders_pkg::*;
#(
    parameter int BOMB_V = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       launch,
    input  logic       kill,
    input  logic [9:0] launch_x,
    input  logic [9:0] launch_y,
    input  logic [9:0] ship_L,
    input  logic [9:0] ship_R,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       bomb_on,
    output logic       bomb_hit,
    output logic       active
);
    logic        active_q, active_d, hit_q, hit_d;
    logic [9:0]  bx_q, bx_d, by_q, by_d;
    logic [10:0] ny;
    logic        x_ovl, y_ovl;

    // Overlap and retirement are judged on the position the bomb is about to take.
    always_comb begin
        ny       = 11'(by_q) + 11'(BOMB_V);
        x_ovl    = (11'(bx_q) + 11'd1 >= 11'(ship_L)) && (bx_q <= ship_R);
        y_ovl    = (ny + 11'd5 >= 11'(SHIP_T)) && (ny <= 11'(SHIP_B));
        active_d = active_q;
        bx_d     = bx_q;
        by_d     = by_q;
        hit_d    = 1'b0;
        if (kill) begin
            active_d = 1'b0;
        end else if (tick) begin
            if (active_q) begin
                if (x_ovl && y_ovl) begin
                    hit_d    = 1'b1;
                    active_d = 1'b0;
                end else if (ny + 11'd5 >= 11'(Y_BOUND)) begin
                    active_d = 1'b0;
                end else begin
                    by_d = ny[9:0];
                end
            end else if (launch) begin
                active_d = 1'b1;
                bx_d     = launch_x;
                by_d     = launch_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
        end else begin
            active_q <= active_d;
            hit_q    <= hit_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
        end
    end

    assign bomb_on  = active_q && (x >= bx_q) && (11'(x) <= 11'(bx_q) + 11'd1)
                    && (y >= by_q) && (11'(y) <= 11'(by_q) + 11'd5);
    assign bomb_hit = hit_q;
    assign active   = active_q;
endmodule

// File: rtl/alien_fleet.sv
// Invader fleet: alive bitmap, march/drop FSM, laser hit resolution and bomb launch.
module alien_fleet
    import invaders_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    parameter int PITCH_LG2 = 5,
    parameter int ALIEN_W   = 24,
    parameter int ALIEN_H   = 16,
    parameter int START_X   = 40,
    parameter int START_Y   = 32,
    parameter int STEP_X    = 2,
    parameter int DROP_Y    = 8,
    parameter int MOVE_DIV  = 4,
    parameter int BOMB_V    = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] laser_T,
    input  logic [9:0] laser_B,
    input  logic [9:0] laser_L,
    input  logic [9:0] laser_R,
    input  logic [9:0] ship_L,
    input  logic [9:0] ship_R,
    output logic       laser_shot,
    output logic       ship_shot,
    output logic       alien_on,
    output logic       bomb_on,
    output logic [5:0] alive_cnt,
    output logic       cleared
);
    localparam int N     = ROWS * COLS;
    localparam int IW    = $clog2(N);
    localparam int PITCH = 1 << PITCH_LG2;

    fleet_state_e  state_q;
    logic [9:0]    fleet_x_q, fleet_y_q;
    logic [N-1:0]  alive_q;
    logic [5:0]    alive_cnt_q;
    logic [7:0]    frame_q, lfsr_q, lfsr_d;
    logic          laser_shot_q, ship_shot_q, cleared_q;

    logic [9:0]    dx, dy, col, row;
    logic [IW-1:0] idx;
    logic          in_grid, alien_px, in_box, hit, tick, marching, step_tick;

    assign tick = (y == 10'(TICK_Y)) && (x == 10'd0);
    assign dx   = x - fleet_x_q;
    assign dy   = y - fleet_y_q;
    assign col  = dx >> PITCH_LG2;
    assign row  = dy >> PITCH_LG2;
    assign idx  = IW'(row * 10'(COLS) + col);

    // Explicit >= compares keep pixels left of / above the fleet from wrapping into the grid.
    assign in_grid  = (x >= fleet_x_q) && (y >= fleet_y_q)
                    && (col < 10'(COLS)) && (row < 10'(ROWS))
                    && ((dx & 10'(PITCH - 1)) < 10'(ALIEN_W))
                    && ((dy & 10'(PITCH - 1)) < 10'(ALIEN_H));
    assign alien_px = in_grid && alive_q[idx] && (state_q != CLEARED);
    assign in_box   = (x >= laser_L) && (x <= laser_R) && (y >= laser_T) && (y <= laser_B);
    assign hit      = video_on && alien_px && in_box && !laser_shot_q && (laser_T > 10'd1);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;
    logic [2:0]      lcol, rcol, lc;
    logic [1:0]      brow, lrow;

    always_comb begin
        col_any = '0;
        row_any = '0;
        lcol    = '0;
        rcol    = '0;
        brow    = '0;
        lrow    = '0;
        lc      = 3'({1'b0, lfsr_q[5:3]} % 4'(COLS));
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (alive_q[r*COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
        for (int c = COLS - 1; c >= 0; c--)
            if (col_any[c]) lcol = 3'(c);
        for (int c = 0; c < COLS; c++)
            if (col_any[c]) rcol = 3'(c);
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) brow = 2'(r);
            if (alive_q[r*COLS + int'(lc)]) lrow = 2'(r);
        end
    end

    logic [10:0] right_edge, left_edge, bottom;
    assign right_edge = 11'(fleet_x_q) + (11'(rcol) << PITCH_LG2) + 11'(ALIEN_W - 1);
    assign left_edge  = 11'(fleet_x_q) + (11'(lcol) << PITCH_LG2);
    assign bottom     = 11'(fleet_y_q) + (11'(brow) << PITCH_LG2) + 11'(ALIEN_H - 1);

    assign lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    assign marching  = (state_q == MARCH_R) || (state_q == MARCH_L)
                    || (state_q == DROP_L)  || (state_q == DROP_R);
    assign step_tick = tick && (frame_q == 8'(MOVE_DIV - 1));

    logic       launch, bomb_hit, bomb_active, bomb_kill;
    logic [9:0] launch_x, launch_y;
    assign launch    = tick && marching && !ship_shot_q && (lfsr_q[2:0] == 3'd0) && col_any[lc];
    assign launch_x  = fleet_x_q + (10'(lc) << PITCH_LG2) + 10'(ALIEN_W / 2 - 1);
    assign launch_y  = fleet_y_q + (10'(lrow) << PITCH_LG2) + 10'(ALIEN_H);
    assign bomb_kill = (alive_cnt_q == 6'd0);

    alien_bomb #(.BOMB_V(BOMB_V)) u_bomb (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .launch   (launch),
        .kill     (bomb_kill),
        .launch_x (launch_x),
        .launch_y (launch_y),
        .ship_L   (ship_L),
        .ship_R   (ship_R),
        .x        (x),
        .y        (y),
        .bomb_on  (bomb_on),
        .bomb_hit (bomb_hit),
        .active   (bomb_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MARCH_R;
            fleet_x_q    <= 10'(START_X);
            fleet_y_q    <= 10'(START_Y);
            alive_q      <= '1;
            alive_cnt_q  <= 6'(N);
            frame_q      <= '0;
            lfsr_q       <= 8'hA5;
            laser_shot_q <= 1'b0;
            ship_shot_q  <= 1'b0;
            cleared_q    <= 1'b0;
        end else begin
            // A retracted laser re-arms even if it grazed an alien this cycle.
            if (laser_T <= 10'd1) laser_shot_q <= 1'b0;
            else if (hit)         laser_shot_q <= 1'b1;
            if (hit) begin
                alive_q[idx] <= 1'b0;
                alive_cnt_q  <= alive_cnt_q - 6'd1;
            end
            if (bomb_hit) ship_shot_q <= 1'b1;
            if (tick) begin
                lfsr_q  <= lfsr_d;
                frame_q <= (frame_q == 8'(MOVE_DIV - 1)) ? 8'd0 : frame_q + 8'd1;
            end
            if (alive_cnt_q == 6'd0 && marching) begin
                state_q   <= CLEARED;
                cleared_q <= 1'b1;
            end else if (step_tick && marching && !ship_shot_q) begin
                if (bottom >= 11'(SHIP_T)) begin
                    state_q     <= LANDED;
                    ship_shot_q <= 1'b1;
                end else begin
                    case (state_q)
                        MARCH_R:
                            if (right_edge + 11'(STEP_X) > 11'(X_BOUND)) state_q <= DROP_L;
                            else fleet_x_q <= fleet_x_q + 10'(STEP_X);
                        MARCH_L:
                            if (left_edge < 11'(STEP_X)) state_q <= DROP_R;
                            else fleet_x_q <= fleet_x_q - 10'(STEP_X);
                        DROP_L: begin
                            fleet_y_q <= fleet_y_q + 10'(DROP_Y);
                            state_q   <= MARCH_L;
                        end
                        DROP_R: begin
                            fleet_y_q <= fleet_y_q + 10'(DROP_Y);
                            state_q   <= MARCH_R;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign laser_shot = laser_shot_q;
    assign ship_shot  = ship_shot_q;
    assign alien_on   = alien_px;
    assign alive_cnt  = alive_cnt_q;
    assign cleared    = cleared_q;
endmodule
